// File: rtl/ram_master_seq_pkg.sv
// Shared definitions for the RAM burst master: FSM state encodings, command
// direction constants and default geometry.
// Optional feature macro: RAM_MASTER_VERIFY_EN adds the write read-back states.
package ram_master_seq_pkg;

  localparam int unsigned DefaultAw = 3;
  localparam int unsigned DefaultDw = 3;

  localparam logic CmdRd = 1'b0;
  localparam logic CmdWr = 1'b1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWrWait  = 3'd1,
    StWrIssue = 3'd2,
    StRdIssue = 3'd3,
    StRdCap   = 3'd4,
    StRdRsp   = 3'd5
`ifdef RAM_MASTER_VERIFY_EN
    ,
    StVfyRd   = 3'd6,
    StVfyCap  = 3'd7
`endif
  } state_e;

endpackage

// File: rtl/ram_burst_ctr.sv
// Burst address/count tracker: loads start address and length on command
// accept, advances one word per step pulse with modulo-2**AW wrap.
module ram_burst_ctr #(
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] load_addr,
  input  logic [AW-1:0] load_len,
  output logic [AW-1:0] cur_addr,
  output logic [AW-1:0] next_addr,
  output logic          last
);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] count_q;
  logic [AW-1:0] len_q;

  // Address/count state; the adder width makes the wrap implicit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
    end else if (load) begin
      addr_q  <= load_addr;
      count_q <= '0;
      len_q   <= load_len;
    end else if (step) begin
      addr_q  <= next_addr;
      count_q <= count_q + AW'(1);
    end
  end

  assign cur_addr  = addr_q;
  assign next_addr = addr_q + AW'(1);
  assign last      = (count_q == len_q);

endmodule

// File: rtl/ram_master_seq.sv
// Burst initiator for a single-port synchronous RAM. Accepts read/write burst
// commands, streams write data in and read data out, and owns the RAM pins.
// Optional feature macro: RAM_MASTER_VERIFY_EN (read-back check, vfy_err port).
module ram_master_seq
  import ram_master_seq_pkg::*;
#(
  parameter int unsigned AW = DefaultAw,
  parameter int unsigned DW = DefaultDw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wd_valid,
  output logic          wd_ready,
  input  logic [DW-1:0] wd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          busy,
  output logic          ram_wr,
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
`ifdef RAM_MASTER_VERIFY_EN
  ,
  output logic          vfy_err
`endif
);

  state_e        state_q;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] next_addr;
  logic          last;
  logic          cmd_fire;
  logic          step;
  logic          wr_word_done;

  assign cmd_fire = (state_q == StIdle) && cmd_valid && cmd_ready;

`ifdef RAM_MASTER_VERIFY_EN
  assign wr_word_done = (state_q == StVfyCap);
`else
  assign wr_word_done = (state_q == StWrIssue);
`endif

  // Advance only between words; the final word leaves the counter untouched
  assign step = !last && (wr_word_done || ((state_q == StRdRsp) && rsp_ready));

  ram_burst_ctr #(
    .AW (AW)
  ) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cmd_fire),
    .step      (step),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .cur_addr  (cur_addr),
    .next_addr (next_addr),
    .last      (last)
  );

  // Burst FSM; every output is registered and strobes default low each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cmd_ready <= 1'b0;
      wd_ready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      busy      <= 1'b0;
      ram_wr    <= 1'b0;
      ram_rd    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
`ifdef RAM_MASTER_VERIFY_EN
      vfy_err   <= 1'b0;
`endif
    end else begin
      ram_wr <= 1'b0;
      ram_rd <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_wr == CmdWr) begin
              state_q  <= StWrWait;
              wd_ready <= 1'b1;
            end else begin
              // Counter loads on this edge, so use the command address directly
              state_q  <= StRdIssue;
              ram_rd   <= 1'b1;
              ram_addr <= cmd_addr;
            end
          end
        end
        StWrWait: begin
          if (wd_valid && wd_ready) begin
            state_q  <= StWrIssue;
            wd_ready <= 1'b0;
            ram_wr   <= 1'b1;
            ram_addr <= cur_addr;
            ram_din  <= wd_data;
          end
        end
`ifdef RAM_MASTER_VERIFY_EN
        StWrIssue: begin
          // Read back the word just written; ram_addr is still held
          state_q <= StVfyRd;
          ram_rd  <= 1'b1;
        end
        StVfyRd: begin
          state_q <= StVfyCap;
        end
        StVfyCap: begin
          if (ram_dout != ram_din) vfy_err <= 1'b1;
          if (last) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            state_q  <= StWrWait;
            wd_ready <= 1'b1;
          end
        end
`else
        StWrIssue: begin
          if (last) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            state_q  <= StWrWait;
            wd_ready <= 1'b1;
          end
        end
`endif
        StRdIssue: begin
          state_q <= StRdCap;
        end
        StRdCap: begin
          state_q   <= StRdRsp;
          rsp_data  <= ram_dout;
          rsp_valid <= 1'b1;
          rsp_last  <= last;
        end
        StRdRsp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            if (rsp_last) begin
              state_q   <= StIdle;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end else begin
              // Counter steps on this edge, so issue the incremented address
              state_q  <= StRdIssue;
              ram_rd   <= 1'b1;
              ram_addr <= next_addr;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master_seq.sv
// Scoreboard bench for ram_master_seq with a behavioural 8x3 synchronous RAM.
// Optional feature macro: RAM_MASTER_VERIFY_EN (exercises vfy_err).
module tb_ram_master_seq;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          wd_valid = 1'b0;
  logic          wd_ready;
  logic [DW-1:0] wd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          busy;
  logic          ram_wr;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
`ifdef RAM_MASTER_VERIFY_EN
  logic          vfy_err;
`endif

  int checks = 0;
  int failures = 0;

  // Expected traffic: {addr,din} writes, read addresses, {data,last} responses
  logic [5:0] exp_wr_q[$];
  logic [2:0] exp_rd_q[$];
  logic [3:0] exp_rsp_q[$];

  logic [DW-1:0] mem [8];
  logic          corrupt = 1'b0;

  always #5 clk = ~clk;

  ram_master_seq #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .ram_wr    (ram_wr),
    .ram_rd    (ram_rd),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
`ifdef RAM_MASTER_VERIFY_EN
    ,
    .vfy_err   (vfy_err)
`endif
  );

  // Behavioural RAM; corrupt flips the LSB of read data
  initial for (int i = 0; i < 8; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    if (ram_rd) ram_dout <= mem[ram_addr] ^ {2'b00, corrupt};
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected traffic whenever the DUT presents it
  initial begin : monitor
    logic [5:0] we;
    logic [2:0] ra;
    logic [3:0] rs;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ram_wr || ram_rd) chk("strobe_exclusive", int'(ram_wr && ram_rd), 0);
        if (ram_wr) begin
          if (exp_wr_q.size() == 0) chk("ram_wr_unexpected", int'(ram_wr), 0);
          else begin
            we = exp_wr_q.pop_front();
            chk("ram_wr_addr", int'(ram_addr), int'(we[5:3]));
            chk("ram_wr_din", int'(ram_din), int'(we[2:0]));
          end
        end
        if (ram_rd) begin
          if (exp_rd_q.size() == 0) chk("ram_rd_unexpected", int'(ram_rd), 0);
          else begin
            ra = exp_rd_q.pop_front();
            chk("ram_rd_addr", int'(ram_addr), int'(ra));
          end
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp_q.size() == 0) chk("rsp_unexpected", int'(rsp_valid), 0);
          else begin
            rs = exp_rsp_q.pop_front();
            chk("rsp_data", int'(rsp_data), int'(rs[3:1]));
            chk("rsp_last", int'(rsp_last), int'(rs[0]));
          end
        end
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [2:0] addr, input logic [2:0] len);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("cmd_accept", int'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_wd(input logic [2:0] d);
    int n = 0;
    wd_valid = 1'b1;
    wd_data  = d;
    @(negedge clk);
    while (!wd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("wd_accept", int'(wd_ready), 1);
    @(posedge clk);
    #1 wd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while ((busy || exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || exp_rsp_q.size() != 0)
           && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("burst_done", int'(busy) + exp_wr_q.size() + exp_rd_q.size() + exp_rsp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic exp_write(input logic [2:0] addr, input logic [2:0] d);
    exp_wr_q.push_back({addr, d});
`ifdef RAM_MASTER_VERIFY_EN
    exp_rd_q.push_back(addr);
`endif
  endtask

  // data packs word i at bits [3*i +: 3]
  task automatic do_write(input logic [2:0] addr, input logic [2:0] len, input logic [23:0] data);
    for (int i = 0; i <= int'(len); i++) exp_write(3'(int'(addr) + i), data[3*i +: 3]);
    send_cmd(1'b1, addr, len);
    for (int i = 0; i <= int'(len); i++) send_wd(data[3*i +: 3]);
    wait_done();
  endtask

  task automatic exp_read(input logic [2:0] addr, input logic [2:0] len, input logic [23:0] data);
    for (int i = 0; i <= int'(len); i++) begin
      exp_rd_q.push_back(3'(int'(addr) + i));
      exp_rsp_q.push_back({data[3*i +: 3], (i == int'(len))});
    end
  endtask

  task automatic do_read(input logic [2:0] addr, input logic [2:0] len, input logic [23:0] data);
    exp_read(addr, len, data);
    send_cmd(1'b0, addr, len);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    // 1: reset values, then cmd_ready rises one cycle after release
    #12;
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wd_ready", int'(wd_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_last", int'(rsp_last), 0);
    chk("rst_ram_wr", int'(ram_wr), 0);
    chk("rst_ram_rd", int'(ram_rd), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_ram_din", int'(ram_din), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready_next", int'(cmd_ready), 1);
    chk("rst_busy_idle", int'(busy), 0);
    @(posedge clk);
    #1;

    // 2: write 7,5,1,4 at 0..3
    do_write(3'd0, 3'd3, {12'd0, 3'd4, 3'd1, 3'd5, 3'd7});
    // 3: read back, last only on 4th
    do_read(3'd0, 3'd3, {12'd0, 3'd4, 3'd1, 3'd5, 3'd7});
    // 4: wrap 6,7,0 with 2,3,6
    do_write(3'd6, 3'd2, {15'd0, 3'd6, 3'd3, 3'd2});
    do_read(3'd6, 3'd2, {15'd0, 3'd6, 3'd3, 3'd2});

    // 5: backpressure on the second word of 6,5,1,4
    exp_read(3'd0, 3'd3, {12'd0, 3'd4, 3'd1, 3'd5, 3'd6});
    rsp_ready = 1'b1;
    send_cmd(1'b0, 3'd0, 3'd3);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("bp_valid", int'(rsp_valid), 1);
    repeat (5) begin
      chk("bp_valid_hold", int'(rsp_valid), 1);
      chk("bp_data_hold", int'(rsp_data), 5);
      chk("bp_last_hold", int'(rsp_last), 0);
      chk("bp_no_ram_rd", int'(ram_rd), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_done();

    // 6: reset while the third of four writes is strobing
    exp_write(3'd0, 3'd2);
    exp_write(3'd1, 3'd4);
    send_cmd(1'b1, 3'd0, 3'd3);
    send_wd(3'd2);
    send_wd(3'd4);
    send_wd(3'd7);
    chk("mid_rst_wr_before", int'(ram_wr), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_drop", int'(ram_wr), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_wd_ready", int'(wd_ready), 0);
    chk("mid_rst_cmd_ready", int'(cmd_ready), 0);
    chk("mid_rst_pending", exp_wr_q.size() + exp_rd_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // aborted word at addr 2 must not have landed
    do_read(3'd0, 3'd3, {12'd0, 3'd4, 3'd1, 3'd4, 3'd2});

`ifdef RAM_MASTER_VERIFY_EN
    chk("vfy_clean", int'(vfy_err), 0);
    corrupt = 1'b1;
    do_write(3'd3, 3'd0, 24'd5);
    corrupt = 1'b0;
    chk("vfy_set", int'(vfy_err), 1);
    do_write(3'd4, 3'd0, 24'd2);
    chk("vfy_sticky", int'(vfy_err), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
